// File: rtl/alu_job_axi_master_pkg.sv
// Shared types and AXI burst constants for the ALU job master.
package alu_job_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        AR,
        R,
        OUT
    } alu_job_state_t;

    localparam logic [3:0] BURST_LEN       = 4'd3;
    localparam logic [2:0] BURST_SIZE_BYTE = 3'b000;
    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [1:0] RESP_OKAY       = 2'b00;

endpackage

// File: rtl/alu_job_axi_master_if.sv
// AXI4 channel bundle between the ALU job master and its byte-wide slave.
interface alu_job_axi_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [3:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/alu_job_axi_master.sv
// ALU job master: writes op1/op2/opcode/pad as a 4-beat burst, reads it back, returns byte 3.
// Optional readback comparison of beats 0..2 is enabled by ALU_JOB_READBACK_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a job, job_ready high
// AW    | write address issued, waiting for awready
// W     | streaming the 4 write beats
// B     | waiting for the write response
// AR    | read address issued, waiting for arready
// R     | collecting the 4 read beats
// OUT   | result held until res_ready
module alu_job_axi_master
    import alu_job_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [ADDR_WIDTH-1:0] job_addr,
    input  logic [DATA_WIDTH-1:0] job_op1,
    input  logic [DATA_WIDTH-1:0] job_op2,
    input  logic [DATA_WIDTH-1:0] job_opcode,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_err,
`ifdef ALU_JOB_READBACK_CHECK_EN
    output logic [2:0]            res_mismatch_mask,
`endif
    alu_job_axi_master_if.master  axi
);

    alu_job_state_t        state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [DATA_WIDTH-1:0] opc_q, opc_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wlast_q, wlast_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_err_q, res_err_d;
    logic [1:0]            beat_nxt;
    logic                  err_v;
`ifdef ALU_JOB_READBACK_CHECK_EN
    logic [2:0]            mask_q, mask_d;
    logic [2:0]            res_mask_q, res_mask_d;
    logic [2:0]            mask_v;
    logic [DATA_WIDTH-1:0] exp_byte;
`endif

    assign beat_nxt = beat_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        opc_d       = opc_q;
        err_d       = err_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wlast_d     = wlast_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        err_v       = err_q;
`ifdef ALU_JOB_READBACK_CHECK_EN
        mask_d      = mask_q;
        res_mask_d  = res_mask_q;
        mask_v      = mask_q;
        exp_byte    = op1_q;
`endif

        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    addr_d    = job_addr;
                    op1_d     = job_op1;
                    op2_d     = job_op2;
                    opc_d     = job_opcode;
                    err_d     = 1'b0;
`ifdef ALU_JOB_READBACK_CHECK_EN
                    mask_d    = 3'b000;
`endif
                    awaddr_d  = job_addr;
                    awvalid_d = 1'b1;
                    state_d   = AW;
                end
            end
            AW: begin
                if (axi.awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wdata_d   = op1_q;
                    wlast_d   = 1'b0;
                    beat_d    = 2'd0;
                    state_d   = W;
                end
            end
            W: begin
                if (axi.wready) begin
                    if (beat_q == 2'd3) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = B;
                    end else begin
                        beat_d  = beat_nxt;
                        wlast_d = (beat_nxt == 2'd3);
                        case (beat_nxt)
                            2'd1:    wdata_d = op2_q;
                            2'd2:    wdata_d = opc_q;
                            default: wdata_d = PAD_BYTE;
                        endcase
                    end
                end
            end
            B: begin
                if (axi.bvalid) begin
                    err_d     = err_q | (axi.bresp != RESP_OKAY);
                    bready_d  = 1'b0;
                    araddr_d  = addr_q;
                    arvalid_d = 1'b1;
                    state_d   = AR;
                end
            end
            AR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = 2'd0;
                    state_d   = R;
                end
            end
            R: begin
                if (axi.rvalid) begin
                    // rlast is only trusted as an error indicator; the beat count always runs to 4
                    err_v = err_q | (axi.rresp != RESP_OKAY) | (axi.rlast != (beat_q == 2'd3));
`ifdef ALU_JOB_READBACK_CHECK_EN
                    case (beat_q)
                        2'd0:    exp_byte = op1_q;
                        2'd1:    exp_byte = op2_q;
                        default: exp_byte = opc_q;
                    endcase
                    if (beat_q != 2'd3 && axi.rdata != exp_byte) begin
                        mask_v[beat_q] = 1'b1;
                    end
                    mask_d = mask_v;
`endif
                    err_d = err_v;
                    if (beat_q == 2'd3) begin
                        rready_d    = 1'b0;
                        res_data_d  = axi.rdata;
                        res_valid_d = 1'b1;
`ifdef ALU_JOB_READBACK_CHECK_EN
                        res_err_d   = err_v | (|mask_v);
                        res_mask_d  = mask_v;
`else
                        res_err_d   = err_v;
`endif
                        state_d     = OUT;
                    end else begin
                        beat_d = beat_nxt;
                    end
                end
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            addr_q      <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            opc_q       <= '0;
            err_q       <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wlast_q     <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
`ifdef ALU_JOB_READBACK_CHECK_EN
            mask_q      <= 3'b000;
            res_mask_q  <= 3'b000;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            opc_q       <= opc_d;
            err_q       <= err_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wlast_q     <= wlast_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
`ifdef ALU_JOB_READBACK_CHECK_EN
            mask_q      <= mask_d;
            res_mask_q  <= res_mask_d;
`endif
        end
    end

    assign job_ready   = (state_q == IDLE);
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
`ifdef ALU_JOB_READBACK_CHECK_EN
    assign res_mismatch_mask = res_mask_q;
`endif

    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = BURST_LEN;
    assign axi.awsize  = BURST_SIZE_BYTE;
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wlast   = wlast_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = BURST_LEN;
    assign axi.arsize  = BURST_SIZE_BYTE;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule

// File: doc/alu_job_axi_master.md
Name: alu_job_axi_master

Overview:
- AXI4 burst master that sits directly upstream of the ALU-equipped AXI4 slave.
- Accepts one ALU job (op1, op2, opcode, base address) on a valid/ready interface.
- Writes a 4-beat INCR burst (op1, op2, opcode, pad), then reads the same 4 bytes back.
- Returns byte 3, the slave-computed result, on a valid/ready result interface with an error flag.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 8, AXI data width; one byte per beat.
- PAD_BYTE, 8'h00, wdata driven on beat 3 (slave overwrites it with the ALU result).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- job_valid  in  1  job request
- job_ready  out  1  job accepted when job_valid&&job_ready
- job_addr  in  ADDR_WIDTH  burst base byte address
- job_op1  in  DATA_WIDTH  operand 1
- job_op2  in  DATA_WIDTH  operand 2
- job_opcode  in  DATA_WIDTH  ALU opcode
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  DATA_WIDTH  ALU result (read beat 3)
- res_err  out  1  any non-OKAY bresp/rresp, wrong rlast, or readback mismatch
- awaddr/awlen/awsize/awburst/awvalid  out  ADDR_WIDTH/4/3/2/1  write address channel
- awready  in  1
- wdata/wlast/wvalid  out  DATA_WIDTH/1/1  write data channel
- wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1
- araddr/arlen/arsize/arburst/arvalid  out  ADDR_WIDTH/4/3/2/1  read address channel
- arready  in  1
- rdata  in  DATA_WIDTH; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1

Behaviour:
- All outputs are registered except job_ready = (state==IDLE).
- Reset values: all valids, bready, rready, wlast and res_err are 0; all address and data outputs are 0; state is IDLE.
- Reset mid-burst aborts immediately, with no cleanup beats.
- Constant burst fields: awlen=arlen=4'd3, awsize=arsize=3'b000, awburst=arburst=2'b01 (INCR).
- States and transitions:
  - IDLE: on job handshake, latch address and operands, clear the error accumulator, load awaddr=job_addr, assert awvalid; go to AW.
  - AW: hold awvalid and awaddr until awready. On handshake, drop awvalid, drive wvalid=1 with wdata=op1 and beat counter 0; go to W.
  - W: on each wvalid&&wready, advance the beat counter. wdata follows op1, op2, opcode, PAD_BYTE. wlast=1 only on beat 3. After beat 3 completes, drop wvalid and set bready=1; go to B.
  - B: on bvalid&&bready, OR (bresp!=0) into the error accumulator, drop bready, load araddr=job_addr, assert arvalid; go to AR.
  - AR: hold arvalid until arready, then drop it, set rready=1 and clear the counter; go to R.
  - R: on each rvalid&&rready, store rdata by beat index and OR (rresp!=0) into the error accumulator. Also flag an error if rlast != (beat==3). After beat 3, drop rready, load res_data=beat-3 byte and res_err, assert res_valid; go to OUT.
  - OUT: hold res_valid and res_data stable until res_ready; then go to IDLE.
- Minimum job latency is 1 (AW) + 4 (W) + 1 (B) + 1 (AR) + 4 (R) + 1 (OUT) cycles from job handshake with zero-wait slave.
- With the companion slave, each read beat costs about 2 cycles because of its RD_WAIT state.
- Valid is never deasserted before its handshake, and payload never changes while valid is high and ready is low.
- If the slave returns rlast early, the master still consumes exactly 4 beats and sets res_err.
- Exactly one outstanding job at a time; job_ready=0 outside IDLE.
- Address arithmetic is the slave's responsibility; the master never splits bursts.
- Callers keep job_addr 4-byte aligned; unaligned addresses are issued unchanged.

Optional Feature:
- Macro: ALU_JOB_READBACK_CHECK_EN.
- When defined: read beats 0..2 are compared with latched op1, op2 and opcode; any mismatch sets res_err. An extra output, res_mismatch_mask[2:0], reports per-byte mismatch, registered with res_data and reset to 0.
- When undefined: beats 0..2 are discarded without storage, there is no comparison logic, and the port is absent.

Decomposition:
- Package alu_job_pkg holds:
  - state enum alu_job_state_t (IDLE, AW, W, B, AR, R, OUT);
  - localparams BURST_LEN=4'd3, BURST_SIZE_BYTE=3'b000, BURST_INCR=2'b01, RESP_OKAY=2'b00.
- No sub-module; single FSM with a 2-bit beat counter.

Test Plan:
- Basic job, zero-wait slave: addr=0x10, op1=5, op2=3, add opcode.
  - Required: 4 write beats 05,03,op,00 with wlast on beat 3, then read.
  - Required: res_data=0x08, res_err=0.
- Backpressure:
  - Stimulus: awready low 3 cycles, wready toggling, rvalid gaps, res_ready low 5 cycles.
  - Required: awvalid/wdata/res_data stable throughout; same result as the unstalled run.
- Error response: bresp=2'b10 (SLVERR) on an otherwise valid job.
  - Required: read still issued, res_err=1, res_data=returned beat 3.
- Early rlast: slave asserts rlast on read beat 1.
  - Required: master still takes 4 beats; res_err=1.
- Reset mid-burst: rstn low during W beat 2, then a new job.
  - Required: all valids 0 the cycle after reset; the next job completes cleanly.
- Readback check (macro on): slave returns beat 1 = 0xFF instead of op2.
  - Required: res_mismatch_mask=3'b010, res_err=1.
